// File: rtl/gcd_datapath.sv
// GCD datapath: x/y working registers with subtract-and-select muxes,
// comparison status toward the controller, iteration counter, zero-operand
// detection and a valid/ready result register toward the consumer.
module gcd_datapath #(
    parameter int W     = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     y_i,
    input  logic             x_ld,
    input  logic             x_sel,
    input  logic             y_ld,
    input  logic             y_sel,
    input  logic             d_ld,
    output logic             x_neq_y,
    output logic             x_lt_y,
    output logic [W-1:0]     d_o,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             zero_op,
    output logic             ovf
);

    logic [W-1:0] x_q;
    logic [W-1:0] y_q;
    logic [W-1:0] x_minus_y;
    logic [W-1:0] y_minus_x;
    logic [W-1:0] result;
    logic         op_load;
    logic         sub_step;
    logic         cnt_sat;
    logic         cap_ok;

    // Both subtract paths see the pre-edge x/y; wrap is modulo 2^W.
    always_comb begin
        x_minus_y = x_q - y_q;
        y_minus_x = y_q - x_q;
        op_load   = x_ld & ~x_sel & y_ld & ~y_sel;
        sub_step  = (x_ld & x_sel) | (y_ld & y_sel);
        cnt_sat   = &iter_cnt;
        // With a zero operand the other one is the GCD; otherwise x==y at done.
        result    = zero_op ? (x_q | y_q) : x_q;
        cap_ok    = d_ld & (~d_valid | d_ready);
        x_neq_y   = ~zero_op & (x_q != y_q);
        x_lt_y    = ~zero_op & (x_q < y_q);
    end

    // x working register: operand load or x - y.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q <= '0;
        end else if (x_ld) begin
            x_q <= x_sel ? x_minus_y : x_i;
        end
    end

    // y working register: operand load or y - x.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_q <= '0;
        end else if (y_ld) begin
            y_q <= y_sel ? y_minus_x : y_i;
        end
    end

    // Iteration counter and zero-operand flag, both restarted by a full operand load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            iter_cnt <= '0;
            zero_op  <= 1'b0;
        end else if (op_load) begin
            iter_cnt <= '0;
            zero_op  <= (x_i == '0) | (y_i == '0);
        end else if (sub_step && !cnt_sat) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    // Result register with valid/ready handshake; a capture into an unconsumed
    // result is dropped and recorded in the sticky overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_o     <= '0;
            d_valid <= 1'b0;
            ovf     <= 1'b0;
        end else if (cap_ok) begin
            d_o     <= result;
            d_valid <= 1'b1;
        end else if (d_ld) begin
            ovf     <= 1'b1;
        end else if (d_valid && d_ready) begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath (W=8, CNT_W=4): table of per-cycle vectors
// plus hand-written saturation and asynchronous-reset sequences.
module tb_gcd_datapath;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST_N;
    logic [W-1:0]     x_i, y_i;
    logic             x_ld, x_sel, y_ld, y_sel, d_ld, d_ready;
    logic             x_neq_y, x_lt_y, d_valid, zero_op, ovf;
    logic [W-1:0]     d_o;
    logic [CNT_W-1:0] iter_cnt;

    int n_vec;
    int n_err;

    gcd_datapath #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .x_i(x_i), .y_i(y_i),
        .x_ld(x_ld), .x_sel(x_sel), .y_ld(y_ld), .y_sel(y_sel),
        .d_ld(d_ld), .x_neq_y(x_neq_y), .x_lt_y(x_lt_y), .d_o(d_o),
        .d_valid(d_valid), .d_ready(d_ready), .iter_cnt(iter_cnt),
        .zero_op(zero_op), .ovf(ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         xl, xs, yl, ys, dl, dr;
        logic [W-1:0] xi, yi;
        logic         e_neq, e_lt;
        logic [W-1:0] e_d;
        logic         e_v;
        logic [3:0]   e_cnt;
        logic         e_z, e_ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_neq, input logic e_lt,
                             input logic [W-1:0] e_d, input logic e_v, input logic [3:0] e_cnt,
                             input logic e_z, input logic e_ovf);
        check({tag, ".x_neq_y"},  int'(x_neq_y),  int'(e_neq));
        check({tag, ".x_lt_y"},   int'(x_lt_y),   int'(e_lt));
        check({tag, ".d_o"},      int'(d_o),      int'(e_d));
        check({tag, ".d_valid"},  int'(d_valid),  int'(e_v));
        check({tag, ".iter_cnt"}, int'(iter_cnt), int'(e_cnt));
        check({tag, ".zero_op"},  int'(zero_op),  int'(e_z));
        check({tag, ".ovf"},      int'(ovf),      int'(e_ovf));
    endtask

    // Drive one cycle's controls (called just after a negedge), sample #1 after posedge.
    task automatic cycle(input logic xl, input logic xs, input logic yl, input logic ys,
                         input logic dl, input logic dr, input logic [W-1:0] xi,
                         input logic [W-1:0] yi);
        x_ld = xl; x_sel = xs; y_ld = yl; y_sel = ys; d_ld = dl; d_ready = dr;
        x_i = xi; y_i = yi;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        @(negedge CLK);
        x_ld = 0; x_sel = 0; y_ld = 0; y_sel = 0; d_ld = 0; d_ready = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //           xl xs yl ys dl dr  xi   yi  neq lt  d  v cnt z ovf
        vecs[0]  = '{1, 0, 1, 0, 0, 0, 12,  8,  1, 0, 0, 0, 0, 0, 0}; // load 12,8
        vecs[1]  = '{1, 1, 0, 0, 0, 0,  0,  0,  1, 1, 0, 0, 1, 0, 0}; // x=4
        vecs[2]  = '{0, 0, 1, 1, 0, 0,  0,  0,  0, 0, 0, 0, 2, 0, 0}; // y=4
        vecs[3]  = '{0, 0, 0, 0, 1, 0,  0,  0,  0, 0, 4, 1, 2, 0, 0}; // capture 4
        vecs[4]  = '{0, 0, 0, 0, 1, 0,  0,  0,  0, 0, 4, 1, 2, 0, 1}; // dropped -> ovf
        vecs[5]  = '{0, 0, 0, 0, 0, 1,  0,  0,  0, 0, 4, 0, 2, 0, 1}; // consumed
        vecs[6]  = '{1, 0, 1, 0, 0, 0,  0,  6,  0, 0, 4, 0, 0, 1, 1}; // load 0,6
        vecs[7]  = '{0, 0, 0, 0, 1, 0,  0,  0,  0, 0, 6, 1, 0, 1, 1}; // capture 0|6
        vecs[8]  = '{1, 0, 1, 0, 0, 0,  9,  6,  1, 0, 6, 1, 0, 0, 1}; // load 9,6
        vecs[9]  = '{1, 1, 1, 1, 0, 0,  0,  0,  1, 1, 6, 1, 1, 0, 1}; // x=3, y=253
        vecs[10] = '{0, 0, 0, 0, 1, 1,  0,  0,  1, 1, 3, 1, 1, 0, 1}; // capture while consumed
        vecs[11] = '{0, 0, 0, 0, 0, 0,  0,  0,  1, 1, 3, 1, 1, 0, 1}; // hold, not ready
        vecs[12] = '{1, 0, 0, 0, 0, 0,  0, 77,  1, 1, 3, 1, 1, 0, 1}; // x-only load: zero_op kept

        RST_N = 0;
        x_ld = 0; x_sel = 0; y_ld = 0; y_sel = 0; d_ld = 0; d_ready = 0;
        x_i = '0; y_i = '0;
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST_N = 1;

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            cycle(vecs[i].xl, vecs[i].xs, vecs[i].yl, vecs[i].ys, vecs[i].dl, vecs[i].dr,
                  vecs[i].xi, vecs[i].yi);
            check_all($sformatf("vec%0d", i), vecs[i].e_neq, vecs[i].e_lt, vecs[i].e_d,
                      vecs[i].e_v, vecs[i].e_cnt, vecs[i].e_z, vecs[i].e_ovf);
        end

        // Saturation: load 255,1 then 254 x-subtracts leaves x==y==1, counter at 15.
        @(negedge CLK);
        cycle(1, 0, 1, 0, 0, 0, 255, 1);
        check("sat.load_neq", int'(x_neq_y), 1);
        check("sat.load_cnt", int'(iter_cnt), 0);
        for (int i = 0; i < 254; i++) begin
            @(negedge CLK);
            cycle(1, 1, 0, 0, 0, 0, 0, 0);
            if (i == 13) check("sat.cnt14", int'(iter_cnt), 14);
            if (i == 14) check("sat.cnt15", int'(iter_cnt), 15);
        end
        check("sat.x_neq_y", int'(x_neq_y), 0);
        check("sat.x_lt_y", int'(x_lt_y), 0);
        check("sat.iter_cnt", int'(iter_cnt), 15);
        @(negedge CLK);
        cycle(0, 0, 0, 0, 1, 1, 0, 0);
        check("sat.d_o", int'(d_o), 1);
        check("sat.d_valid", int'(d_valid), 1);
        check("sat.cnt_hold", int'(iter_cnt), 15);

        // Asynchronous reset mid-run with x=4, y=8 after one y-subtract.
        @(negedge CLK);
        cycle(1, 0, 1, 0, 0, 0, 4, 8);
        check("rst.pre_lt", int'(x_lt_y), 1);
        @(negedge CLK);
        cycle(0, 0, 1, 1, 0, 0, 0, 0);
        check("rst.pre_cnt", int'(iter_cnt), 1);
        check("rst.pre_neq", int'(x_neq_y), 0);
        idle();
        #2;
        RST_N = 0;
        #1;
        check_all("rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);
        check_all("rst.after", 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
